// File: rtl/flag_update_ctrl.sv
// Sequencer between decoder, ALU and status-flag register: issues one ALU op,
// waits for completion (with timeout), commits masked ZCSO flags, evaluates branch conditions.
module flag_update_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [4:0] req_op,
    output logic       req_ready,
    output logic       alu_start,
    output logic [4:0] alu_op,
    input  logic       alu_done,
    input  logic       alu_z,
    input  logic       alu_c,
    input  logic       alu_s,
    input  logic       alu_o,
    output logic [3:0] zcso,
    output logic [3:0] flag_mask,
    output logic       flags_we,
    output logic       busy,
    output logic       timeout_err,
    input  logic [2:0] cond_sel,
    output logic       cond_true
);

    localparam int unsigned OP_W   = 5;
    localparam int unsigned FLAG_W = 4;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        COMMIT
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   counter;
    logic [FLAG_W-1:0]  alu_flags;

    assign alu_flags = {alu_o, alu_s, alu_c, alu_z};

    // Per-opcode flag update mask, bit order {O,S,C,Z}
    function automatic logic [FLAG_W-1:0] mask_decode(input logic [OP_W-1:0] op);
        logic [FLAG_W-1:0] m;
        m = '0;
        case (op)
            5'b01000, 5'b01001:                     m = 4'b0111;
            5'b00000, 5'b00001, 5'b00011,
            5'b00100, 5'b00101, 5'b00110:           m = 4'b1111;
            5'b10001, 5'b10010:                     m = 4'b0101;
            default: begin
                if (op >= 5'b10100 && op <= 5'b11110) begin
                    m = 4'b0101;
                end
            end
        endcase
        return m;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            counter     <= '0;
            zcso        <= '0;
            flag_mask   <= '0;
            alu_op      <= '0;
            alu_start   <= 1'b0;
            flags_we    <= 1'b0;
            busy        <= 1'b0;
            req_ready   <= 1'b1;
            timeout_err <= 1'b0;
        end else begin
            alu_start <= 1'b0;
            flags_we  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        alu_op      <= req_op;
                        flag_mask   <= mask_decode(req_op);
                        timeout_err <= 1'b0;
                        alu_start   <= 1'b1;
                        busy        <= 1'b1;
                        req_ready   <= 1'b0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    counter <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    // A completion on the last allowed cycle beats the timeout
                    if (alu_done) begin
                        zcso     <= (zcso & ~flag_mask) | (alu_flags & flag_mask);
                        flags_we <= |flag_mask;
                        state    <= COMMIT;
                    end else if (counter == CNT_LAST) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        req_ready   <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                COMMIT: begin
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Branch condition from committed flags, zcso = {O,S,C,Z}
    always_comb begin
        cond_true = 1'b0;
        case (cond_sel)
            3'd0:    cond_true = 1'b1;
            3'd1:    cond_true = zcso[0];
            3'd2:    cond_true = ~zcso[0];
            3'd3:    cond_true = zcso[1];
            3'd4:    cond_true = zcso[2];
            3'd5:    cond_true = zcso[3];
            3'd6:    cond_true = ~zcso[2] & ~zcso[0];
            3'd7:    cond_true = zcso[2] | zcso[0];
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_flag_update_ctrl.sv
// Directed self-checking bench for flag_update_ctrl with hand-computed expectations.
module tb_flag_update_ctrl;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic [4:0] req_op;
    logic       req_ready;
    logic       alu_start;
    logic [4:0] alu_op;
    logic       alu_done;
    logic       alu_z, alu_c, alu_s, alu_o;
    logic [3:0] zcso;
    logic [3:0] flag_mask;
    logic       flags_we;
    logic       busy;
    logic       timeout_err;
    logic [2:0] cond_sel;
    logic       cond_true;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cnt = 0;
    int we_cnt    = 0;
    logic [3:0] we_z;
    logic [3:0] zexp;

    flag_update_ctrl #(.TIMEOUT(16), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_ready  (req_ready),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .alu_done   (alu_done),
        .alu_z      (alu_z),
        .alu_c      (alu_c),
        .alu_s      (alu_s),
        .alu_o      (alu_o),
        .zcso       (zcso),
        .flag_mask  (flag_mask),
        .flags_we   (flags_we),
        .busy       (busy),
        .timeout_err(timeout_err),
        .cond_sel   (cond_sel),
        .cond_true  (cond_true)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (alu_start) start_cnt <= start_cnt + 1;
        if (flags_we) begin
            we_cnt <= we_cnt + 1;
            we_z   <= zcso;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_flags(input logic [3:0] f);
        alu_z = f[0];
        alu_c = f[1];
        alu_s = f[2];
        alu_o = f[3];
    endtask

    // Runs one operation from IDLE; alu_done raised d cycles after alu_start
    task automatic run_op(input logic [4:0] op, input logic [3:0] exp_m, input int d,
                          input logic [3:0] f, input bit give_done, input bit hold,
                          output int gap);
        int acc, n, s0, w0;
        logic [31:0] exp_we;
        s0 = start_cnt;
        w0 = we_cnt;
        req_op    = op;
        req_valid = 1'b1;
        acc       = cyc;
        @(posedge clk); #1;
        if (hold) req_op = ~op;
        else      req_valid = 1'b0;
        check("issue_start", alu_start, 1);
        check("issue_busy", busy, 1);
        check("issue_ready", req_ready, 0);
        check("issue_alu_op", alu_op, op);
        check("issue_mask", flag_mask, exp_m);
        check("issue_terr", timeout_err, 0);
        if (give_done) begin
            if (d >= 2) begin
                alu_done = 1'b1;
                set_flags(~f);
            end
            repeat (d) begin
                @(posedge clk); #1;
                alu_done = 1'b0;
            end
            check("wait_alu_op", alu_op, op);
            set_flags(f);
            alu_done = 1'b1;
            @(posedge clk); #1;
            alu_done = 1'b0;
            zexp = (zexp & ~exp_m) | (f & exp_m);
        end
        n = 0;
        while (!req_ready && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        req_valid = 1'b0;
        gap = cyc - acc;
        exp_we = (give_done && exp_m != 4'b0000) ? 32'd1 : 32'd0;
        check("ready_back", req_ready, 1);
        check("busy_clear", busy, 0);
        check("start_pulses", start_cnt - s0, 1);
        check("we_pulses", we_cnt - w0, exp_we);
        check("zcso", zcso, zexp);
        if (exp_we != 0) check("we_zcso", we_z, zexp);
    endtask

    logic [4:0] t_op [10];
    logic [3:0] t_m  [10];
    logic [7:0] cexp;
    int gap;

    initial begin
        t_op[0] = 5'b00011; t_m[0] = 4'b1111;
        t_op[1] = 5'b01001; t_m[1] = 4'b0111;
        t_op[2] = 5'b10001; t_m[2] = 4'b0101;
        t_op[3] = 5'b10010; t_m[3] = 4'b0101;
        t_op[4] = 5'b11110; t_m[4] = 4'b0101;
        t_op[5] = 5'b11111; t_m[5] = 4'b0000;
        t_op[6] = 5'b10011; t_m[6] = 4'b0000;
        t_op[7] = 5'b00111; t_m[7] = 4'b0000;
        t_op[8] = 5'b10000; t_m[8] = 4'b0000;
        t_op[9] = 5'b00110; t_m[9] = 4'b1111;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        alu_done  = 1'b0;
        set_flags(4'b0000);
        cond_sel  = '0;
        zexp      = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_zcso", zcso, 0);
        check("rst_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_terr", timeout_err, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_mask", flag_mask, 0);
        check("rst_start", alu_start, 0);
        check("rst_we", flags_we, 0);

        // Basic op: Z=1 C=0 S=1 O=1, done 3 cycles after start
        run_op(5'b00000, 4'b1111, 3, 4'b1101, 1'b1, 1'b0, gap);
        check("basic_zcso", zcso, 4'b1101);
        check("basic_gap", gap, 6);

        // Partial masks: preload 1111, then ZCS and ZS updates
        run_op(5'b00000, 4'b1111, 1, 4'b1111, 1'b1, 1'b0, gap);
        check("pre_gap", gap, 4);
        run_op(5'b01000, 4'b0111, 2, 4'b0000, 1'b1, 1'b1, gap);
        check("zcs_zcso", zcso, 4'b1000);
        run_op(5'b10100, 4'b0101, 1, 4'b1111, 1'b1, 1'b0, gap);
        check("zs_zcso", zcso, 4'b1101);

        // No-mask op leaves flags and never pulses flags_we
        run_op(5'b00010, 4'b0000, 2, 4'b1111, 1'b1, 1'b0, gap);
        check("none_zcso", zcso, 4'b1101);

        for (int i = 0; i < 10; i++) begin
            run_op(t_op[i], t_m[i], 1 + (i % 3), (i % 2 == 1) ? 4'b1010 : 4'b0101,
                   1'b1, 1'b0, gap);
            check("tbl_gap", gap, 4 + (i % 3));
        end

        // Timeout: alu_done never arrives
        run_op(5'b00000, 4'b1111, 0, 4'b0000, 1'b0, 1'b0, gap);
        check("to_gap", gap, 18);
        check("to_terr", timeout_err, 1);
        // Completion on the 16th WAIT cycle still commits; new request clears error
        run_op(5'b00001, 4'b1111, 16, 4'b0011, 1'b1, 1'b0, gap);
        check("late_gap", gap, 19);
        check("late_terr", timeout_err, 0);
        check("late_zcso", zcso, 4'b0011);

        // Condition sweeps
        run_op(5'b00000, 4'b1111, 1, 4'b0101, 1'b1, 1'b0, gap);
        cexp = 8'b10010011;
        for (int s = 0; s < 8; s++) begin
            cond_sel = 3'(s);
            #1;
            check("cond_0101", cond_true, cexp[s]);
        end
        run_op(5'b00000, 4'b1111, 1, 4'b1010, 1'b1, 1'b0, gap);
        cexp = 8'b01101101;
        for (int s = 0; s < 8; s++) begin
            cond_sel = 3'(s);
            #1;
            check("cond_1010", cond_true, cexp[s]);
        end

        // Reset during WAIT abandons the op; late alu_done is ignored
        req_op    = 5'b00000;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mrst_zcso", zcso, 0);
        check("mrst_ready", req_ready, 1);
        check("mrst_busy", busy, 0);
        check("mrst_mask", flag_mask, 0);
        zexp = 4'b0000;
        begin
            int w0;
            w0 = we_cnt;
            set_flags(4'b1111);
            alu_done = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            alu_done = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            check("late_done_zcso", zcso, 0);
            check("late_done_we", we_cnt - w0, 0);
            check("late_done_ready", req_ready, 1);
        end
        run_op(5'b00100, 4'b1111, 1, 4'b0001, 1'b1, 1'b0, gap);
        check("post_rst_zcso", zcso, 4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/flag_update_ctrl.md
Name: flag_update_ctrl

Overview:
- Sequencer between the instruction decoder, the ALU and the status-flag register.
- Accepts one ALU operation at a time through a valid/ready handshake, issues it to the ALU and waits for ALU completion.
- On completion, commits the ALU's Z/C/S/O flags into the held flag word (ZCSO), using a per-opcode update mask.
- Provides a combinational branch-condition evaluation from the committed flags, and detects a hung ALU with a timeout.

Parameters:
- TIMEOUT, 16, max WAIT cycles without alu_done before abort (legal range 2..255).
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  decoder presents an operation.
- req_op  in  5  ALU/flag-control opcode (C_RE encoding).
- req_ready  out  1  controller can accept (high only in IDLE).
- alu_start  out  1  one-cycle pulse launching the ALU.
- alu_op  out  5  latched opcode, stable from ISSUE until return to IDLE.
- alu_done  in  1  ALU result/flags valid this cycle.
- alu_z, alu_c, alu_s, alu_o  in  1 each  raw ALU flags, sampled only with alu_done.
- zcso  out  4  committed flags: [0]=Z, [1]=C, [2]=S, [3]=O.
- flag_mask  out  4  update mask of the latched opcode, same bit order as zcso.
- flags_we  out  1  one-cycle pulse, high in the cycle new zcso first appears.
- busy  out  1  high in ISSUE, WAIT and COMMIT.
- timeout_err  out  1  sticky abort flag; cleared on the next accepted request.
- cond_sel  in  3  branch condition select.
- cond_true  out  1  combinational condition result from zcso.

Behaviour:
- Reset (rst_n low at a clock edge) forces the following; reset mid-operation abandons the op with no flag write:
  - state=IDLE
  - zcso=4'b0000, flag_mask=0
  - alu_op=0, alu_start=0, flags_we=0
  - busy=0, timeout_err=0
  - counter=0
- Mask decode on req_op:
  - 01000, 01001 -> ZCS (4'b0111).
  - 00000, 00001, 00011, 00100, 00101, 00110 -> all (4'b1111).
  - 10001, 10010, 10100..11110 -> ZS (4'b0101).
  - Any other code -> none (4'b0000).
- IDLE: req_ready=1. If req_valid, latch req_op into alu_op and its mask into flag_mask, clear timeout_err, go to ISSUE.
- ISSUE (1 cycle): alu_start=1, counter cleared, go to WAIT. alu_done during ISSUE is ignored.
- WAIT, alu_done=1: for each set mask bit, load the matching alu_* flag into zcso. Unmasked bits hold. Go to COMMIT.
- WAIT, alu_done=0:
  - counter increments.
  - When the counter reaches TIMEOUT-1 and alu_done is still low, set timeout_err=1, leave zcso unchanged, go to IDLE.
  - alu_done on that same cycle wins over the timeout.
- COMMIT (1 cycle): flags_we=1 only if flag_mask!=0, then go to IDLE.
- Latency: accept at cycle N -> alu_start at N+1. alu_done at N+1+k (k>=1) -> new zcso and flags_we at N+2+k. req_ready again at N+3+k.
- Back-to-back: a req_valid held high is accepted in the first IDLE cycle after COMMIT. No request is accepted while busy.
- alu_done outside WAIT is ignored.
- cond_sel decode:
  - 0: always 1
  - 1: Z
  - 2: !Z
  - 3: C
  - 4: S
  - 5: O
  - 6: !S & !Z
  - 7: S | Z
- cond_true reflects zcso purely combinationally; it updates in the same cycle flags_we rises.

Test Plan:
- Reset with zcso preloaded by a prior op -> after one rst_n-low edge, zcso=0000, req_ready=1, timeout_err=0, busy=0.
- req_op=00000, alu_done 3 cycles after alu_start with Z=1, C=0, S=1, O=1 -> zcso=1101, flags_we single pulse, alu_start exactly one pulse, accept-to-ready gap = 6 cycles.
- Start from zcso=1111; op 01000 with ALU flags 0000 -> zcso=1000 (O held). Then op 10100 with ALU flags 1111 -> zcso=1101 (C held).
- Op 00010 (mask none) with ALU flags 1111 -> zcso unchanged, flags_we never asserted, FSM returns to IDLE.
- TIMEOUT=16, alu_done never asserted -> timeout_err=1 after 16 WAIT cycles, zcso unchanged, req_ready=1. A new request clears timeout_err. A second run with alu_done on the 16th WAIT cycle commits with timeout_err=0.
- rst_n low during WAIT of op 00000 -> IDLE next cycle, zcso=0000. A late alu_done is ignored. Separately, sweep cond_sel 0..7 with zcso=0101 -> cond_true=1,1,0,0,1,0,0,1.
